// File: rtl/stream_not_pkg.sv
// Shared types and defaults for the stream_not_stage slice.
package stream_not_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/not_vector.sv
// Combinational bitwise NOT built from one constant-input 2:1 mux per bit.
module not_vector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Each bit selects between constant 0 (bit set) and constant 1 (bit clear).
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign dout[i] = din[i] ? 1'b0 : 1'b1;
  end

endmodule

// File: rtl/stream_not_stage.sv
// Registered valid/ready stage emitting ~up_data through a 2-entry skid buffer.
// Optional transfer counter enabled by defining STREAM_NOT_STATS_EN.
module stream_not_stage
  import stream_not_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [WIDTH-1:0] down_data
`ifdef STREAM_NOT_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] inv_data;
  logic             up_xfer;
  logic             down_xfer;

  assign up_xfer   = up_vld & up_rdy;
  assign down_xfer = down_vld & down_rdy;

  not_vector #(
    .WIDTH(WIDTH)
  ) u_not (
    .din (up_data),
    .dout(inv_data)
  );

  // up_rdy and down_vld are registered alongside the state so neither depends
  // combinationally on the other side of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      up_rdy    <= 1'b0;
      down_vld  <= 1'b0;
      down_data <= '0;
      skid      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          up_rdy <= 1'b1;
          if (up_xfer) begin
            down_data <= inv_data;
            down_vld  <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (up_xfer && down_xfer) begin
            down_data <= inv_data;
          end else if (down_xfer) begin
            down_vld <= 1'b0;
            state    <= EMPTY;
          end else if (up_xfer) begin
            skid   <= inv_data;
            up_rdy <= 1'b0;
            state  <= FULL;
          end
        end
        FULL: begin
          if (down_xfer) begin
            down_data <= skid;
            up_rdy    <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          up_rdy   <= 1'b1;
          down_vld <= 1'b0;
          state    <= EMPTY;
        end
      endcase
    end
  end

`ifdef STREAM_NOT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (down_xfer) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

`ifndef SYNTHESIS
  // A stalled upstream word must be held unchanged until it is accepted.
  a_up_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (up_vld && !up_rdy) |=> (up_vld && $stable(up_data)));
`endif

endmodule

// File: tb/tb_stream_not_stage.sv
// Scoreboard bench for stream_not_stage; define STREAM_NOT_STATS_EN to cover xfer_cnt.
module tb_stream_not_stage;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             up_vld;
  logic             up_rdy;
  logic [WIDTH-1:0] up_data;
  logic             down_vld;
  logic             down_rdy;
  logic [WIDTH-1:0] down_data;
`ifdef STREAM_NOT_STATS_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  logic [WIDTH-1:0] exp_q[$];

  stream_not_stage #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_vld   (up_vld),
    .up_rdy   (up_rdy),
    .up_data  (up_data),
    .down_vld (down_vld),
    .down_rdy (down_rdy),
    .down_data(down_data)
`ifdef STREAM_NOT_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples at the falling edge, records the upstream word into the scoreboard,
  // then advances to just after the next rising edge.
  task automatic tick(output logic ux, output logic dx, output logic rdy, output logic vld,
                      output logic [WIDTH-1:0] dd);
    @(negedge clk);
    ux  = up_vld && up_rdy;
    dx  = down_vld && down_rdy;
    rdy = up_rdy;
    vld = down_vld;
    dd  = down_data;
    if (ux) exp_q.push_back(~up_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ux, dx, rdy, vld;
    logic [WIDTH-1:0] dd;
    rst_n    = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'hA5;
    down_rdy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick(ux, dx, rdy, vld, dd);
      checks++;
      if (rdy !== 1'b0) begin
        fails++; $display("FAIL reset_up_rdy cyc %0d: got %b want 0", i, rdy);
      end
      checks++;
      if (vld !== 1'b0) begin
        fails++; $display("FAIL reset_down_vld cyc %0d: got %b want 0", i, vld);
      end
      checks++;
      if (dd !== 8'h00) begin
        fails++; $display("FAIL reset_down_data cyc %0d: got %h want 00", i, dd);
      end
`ifdef STREAM_NOT_STATS_EN
      checks++;
      if (xfer_cnt !== '0) begin
        fails++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt);
      end
`endif
    end
    up_vld = 1'b0;
    rst_n  = 1'b1;
    tick(ux, dx, rdy, vld, dd);
    tick(ux, dx, rdy, vld, dd);
    checks++;
    if (rdy !== 1'b1) begin
      fails++; $display("FAIL release_up_rdy: got %b want 1", rdy);
    end
    checks++;
    if (vld !== 1'b0) begin
      fails++; $display("FAIL release_down_vld: got %b want 0", vld);
    end
  endtask

  task automatic test_streaming();
    logic ux, dx, rdy, vld;
    logic [WIDTH-1:0] dd, exp;
    logic [WIDTH-1:0] words[3];
    logic             want_dx[5];
    words   = '{8'h00, 8'hFF, 8'h3C};
    want_dx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    down_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_vld = (i < 3);
      if (i < 3) up_data = words[i];
      tick(ux, dx, rdy, vld, dd);
      checks++;
      if (dx !== want_dx[i]) begin
        fails++; $display("FAIL stream_valid cyc %0d: got %b want %b", i, dx, want_dx[i]);
      end
      if (dx) begin
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (dd !== exp) begin
          fails++; $display("FAIL stream_data cyc %0d: got %h want %h", i, dd, exp);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic ux, dx, rdy, vld;
    logic [WIDTH-1:0] dd, exp;
    down_rdy = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'h12;
    tick(ux, dx, rdy, vld, dd);
    up_data = 8'h34;
    tick(ux, dx, rdy, vld, dd);
    up_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(ux, dx, rdy, vld, dd);
      checks++;
      if (rdy !== 1'b0) begin
        fails++; $display("FAIL bp_up_rdy cyc %0d: got %b want 0", i, rdy);
      end
      checks++;
      if (vld !== 1'b1 || dd !== 8'hED) begin
        fails++; $display("FAIL bp_hold cyc %0d: got vld %b data %h want 1 ED", i, vld, dd);
      end
    end
    down_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(ux, dx, rdy, vld, dd);
      checks++;
      if (dx !== (i < 2)) begin
        fails++; $display("FAIL drain_valid cyc %0d: got %b want %b", i, dx, (i < 2));
      end
      if (dx) begin
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (dd !== exp) begin
          fails++; $display("FAIL drain_data cyc %0d: got %h want %h", i, dd, exp);
        end
      end
      if (i < 2) begin
        checks++;
        if (rdy !== (i == 1)) begin
          fails++; $display("FAIL drain_up_rdy cyc %0d: got %b want %b", i, rdy, (i == 1));
        end
      end
    end
  endtask

  task automatic test_random_stall();
    logic ux, dx, rdy, vld, hold_prev;
    logic [WIDTH-1:0] dd, exp, data_prev;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    hold_prev = 1'b0;
    data_prev = '0;
    up_vld    = 1'b0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (!up_vld && sent < 1000 && $urandom_range(0, 1) == 1) begin
        up_vld  = 1'b1;
        up_data = WIDTH'($urandom);
      end
      down_rdy = ($urandom_range(0, 1) == 1);
      tick(ux, dx, rdy, vld, dd);
      if (hold_prev) begin
        checks++;
        if (dd !== data_prev) begin
          fails++; $display("FAIL stall_stable cyc %0d: got %h want %h", cyc, dd, data_prev);
        end
      end
      hold_prev = vld && !down_rdy;
      data_prev = dd;
      if (ux) begin
        sent++;
        up_vld = 1'b0;
      end
      if (dx) begin
        got++;
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (dd !== exp) begin
          fails++; $display("FAIL random_data word %0d: got %h want %h", got, dd, exp);
        end
      end
      cyc++;
    end
    down_rdy = 1'b1;
    checks++;
    if (got != 1000 || sent != 1000) begin
      fails++; $display("FAIL random_count: got %0d sent %0d want 1000", got, sent);
    end
  endtask

  task automatic test_reset_mid();
    logic ux, dx, rdy, vld;
    logic [WIDTH-1:0] dd;
    int n = 0;
    int cyc = 0;
    down_rdy = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'h01;
    tick(ux, dx, rdy, vld, dd);
    up_data = 8'h02;
    tick(ux, dx, rdy, vld, dd);
    up_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (up_rdy !== 1'b0 || down_vld !== 1'b0 || down_data !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_outputs: got rdy %b vld %b data %h want 0 0 00",
               up_rdy, down_vld, down_data);
    end
    exp_q.delete();
    #1 rst_n = 1'b1;
    down_rdy = 1'b1;
    up_vld   = 1'b1;
    up_data  = 8'h0F;
    ux = 1'b0;
    while (!ux && cyc < 10) begin
      tick(ux, dx, rdy, vld, dd);
      cyc++;
    end
    up_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(ux, dx, rdy, vld, dd);
      if (dx) begin
        n++;
        checks++;
        if (dd !== 8'hF0) begin
          fails++; $display("FAIL mid_reset_data: got %h want F0", dd);
        end
      end
    end
    checks++;
    if (n != 1) begin
      fails++; $display("FAIL mid_reset_count: got %0d want 1", n);
    end
    exp_q.delete();
  endtask

`ifdef STREAM_NOT_STATS_EN
  task automatic test_stats();
    logic ux, dx, rdy, vld;
    logic [WIDTH-1:0] dd;
    int ntx = 0;
    rst_n  = 1'b0;
    up_vld = 1'b0;
    #3 rst_n = 1'b1;
    exp_q.delete();
    tick(ux, dx, rdy, vld, dd);
    down_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      up_vld  = (i < 17);
      up_data = WIDTH'(i);
      tick(ux, dx, rdy, vld, dd);
      if (dx) ntx++;
    end
    checks++;
    if (ntx != 17) begin
      fails++; $display("FAIL stats_transfers: got %0d want 17", ntx);
    end
    checks++;
    if (xfer_cnt !== CNT_W'(1)) begin
      fails++; $display("FAIL stats_wrap: got %0d want 1", xfer_cnt);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    up_vld   = 1'b0;
    up_data  = '0;
    down_rdy = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_random_stall();
    test_reset_mid();
`ifdef STREAM_NOT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
